// File: rtl/prime_scan_if.sv
// Handshake bundle for prime_scan: mode/start/candidate in, result and status out.
// The master side drives the requests; the slave side is the scanner itself.
interface prime_scan_if #(
   parameter int WIDTH = 16
);
   logic             auto_en;
   logic             start;
   logic [WIDTH-1:0] num_in;
   logic             ready;
   logic             valid;
   logic             is_prime;
   logic [WIDTH-1:0] number;
   logic [WIDTH-1:0] prime_count;

   modport master (
      output auto_en,
      output start,
      output num_in,
      input  ready,
      input  valid,
      input  is_prime,
      input  number,
      input  prime_count
   );

   modport slave (
      input  auto_en,
      input  start,
      input  num_in,
      output ready,
      output valid,
      output is_prime,
      output number,
      output prime_count
   );
endinterface

// File: rtl/prime_scan.sv
// Trial-division primality tester with a single-test mode and a paced auto-scan mode.
// Each divisor is checked by a WIDTH-cycle restoring shift-subtract remainder.
module prime_scan #(
   parameter int WIDTH     = 16,
   parameter int PACE_BITS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   prime_scan_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      DIV,
      EVAL,
      DONE
   } state_t;

   state_t               state_q;
   logic [WIDTH-1:0]     number_q;
   logic [WIDTH-1:0]     divisor_q;
   logic [WIDTH-1:0]     dividend_q;
   logic [WIDTH:0]       remainder_q;
   logic [CW-1:0]        bitCnt_q;
   logic [WIDTH-1:0]     primeCount_q;
   logic [PACE_BITS-1:0] paceCnt_q;
   logic                 ready_q;
   logic                 valid_q;
   logic                 isPrime_q;

   logic [2*WIDTH-1:0]   divSquare;
   logic                 divSquareBig;
   logic                 paceTick;
   logic [WIDTH:0]       remShift;
   logic [WIDTH:0]       remSub;
   logic                 remFits;

   // The divisor square is kept at full double width so large candidates never alias.
   always_comb begin
      divSquare    = (2*WIDTH)'(divisor_q) * (2*WIDTH)'(divisor_q);
      divSquareBig = divSquare > (2*WIDTH)'(number_q);
      paceTick     = &paceCnt_q;
      remShift     = {remainder_q[WIDTH-1:0], dividend_q[WIDTH-1]};
      remSub       = remShift - {1'b0, divisor_q};
      remFits      = remShift >= {1'b0, divisor_q};
   end

   // Free-running pacing counter; the auto-scan only launches when it is all-ones.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         paceCnt_q <= '0;
      end else begin
         paceCnt_q <= paceCnt_q + PACE_BITS'(1);
      end
   end

   // Main controller: all status outputs are registered alongside the state.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q      <= IDLE;
         number_q     <= '0;
         divisor_q    <= WIDTH'(2);
         dividend_q   <= '0;
         remainder_q  <= '0;
         bitCnt_q     <= '0;
         primeCount_q <= '0;
         ready_q      <= 1'b1;
         valid_q      <= 1'b0;
         isPrime_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.auto_en) begin
                  if (paceTick) begin
                     number_q  <= number_q + WIDTH'(1);
                     divisor_q <= WIDTH'(2);
                     ready_q   <= 1'b0;
                     state_q   <= CHECK;
                  end
               end else if (bus.start) begin
                  number_q  <= bus.num_in;
                  divisor_q <= WIDTH'(2);
                  ready_q   <= 1'b0;
                  state_q   <= CHECK;
               end
            end

            CHECK: begin
               if (number_q < WIDTH'(2)) begin
                  isPrime_q <= 1'b0;
                  valid_q   <= 1'b1;
                  state_q   <= DONE;
               end else if (divSquareBig) begin
                  isPrime_q <= 1'b1;
                  valid_q   <= 1'b1;
                  if (primeCount_q != '1) begin
                     primeCount_q <= primeCount_q + WIDTH'(1);
                  end
                  state_q   <= DONE;
               end else begin
                  dividend_q  <= number_q;
                  remainder_q <= '0;
                  bitCnt_q    <= '0;
                  state_q     <= DIV;
               end
            end

            // One quotient bit per cycle, MSB first; only the remainder is kept.
            DIV: begin
               remainder_q <= remFits ? remSub : remShift;
               dividend_q  <= {dividend_q[WIDTH-2:0], 1'b0};
               bitCnt_q    <= bitCnt_q + CW'(1);
               if (bitCnt_q == CW'(WIDTH - 1)) begin
                  state_q <= EVAL;
               end
            end

            EVAL: begin
               if (remainder_q == '0) begin
                  isPrime_q <= 1'b0;
                  valid_q   <= 1'b1;
                  state_q   <= DONE;
               end else begin
                  divisor_q <= (divisor_q == WIDTH'(2)) ? WIDTH'(3) : divisor_q + WIDTH'(2);
                  state_q   <= CHECK;
               end
            end

            DONE: begin
               valid_q <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end

            default: begin
               valid_q <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.ready       = ready_q;
   assign bus.valid       = valid_q;
   assign bus.is_prime    = isPrime_q;
   assign bus.number      = number_q;
   assign bus.prime_count = primeCount_q;

endmodule

// File: tb/tb_prime_scan.sv
// Self-checking bench for prime_scan (WIDTH=8, PACE_BITS=2): directed, random,
// abort and auto-scan scenarios compared against a plain trial-division model.
module tb_prime_scan;

   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   modelCount;

   prime_scan_if #(.WIDTH(W)) bus ();

   prime_scan #(.WIDTH(W), .PACE_BITS(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit isPrimeRef(input int n);
      if (n < 2) return 1'b0;
      for (int d = 2; d * d <= n; d++) begin
         if (n % d == 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Edges from capture until valid is seen: one base cycle, W+2 per trial divisor,
   // one extra for the final square test on a prime; 0 and 1 resolve at once.
   function automatic int expLatency(input int n);
      int k;
      int d;
      if (n < 2) return 2;
      k = 0;
      d = 2;
      while (d * d <= n) begin
         k++;
         if (n % d == 0) return 1 + k * (W + 2);
         d = (d == 2) ? 3 : d + 2;
      end
      return 1 + k * (W + 2) + 1;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic waitReady(input string tag);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!bus.ready && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 500) checkOutput({tag, "-readyTimeout"}, 0, 1);
   endtask

   // Single-mode test of one candidate with latency, result, number and count checks.
   task automatic applyStimulus(input int n, input string tag);
      int lat;
      bit seen;
      waitReady(tag);
      bus.num_in = W'(n);
      bus.start  = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      lat  = 0;
      seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
         @(negedge clk);
         lat++;
         if (bus.valid) seen = 1'b1;
      end
      checkOutput({tag, "-seen"}, 32'(seen), 1);
      checkOutput({tag, "-lat"}, lat, expLatency(n));
      checkOutput({tag, "-prime"}, 32'(bus.is_prime), 32'(isPrimeRef(n)));
      checkOutput({tag, "-number"}, 32'(bus.number), n);
      if (isPrimeRef(n) && modelCount < 255) modelCount++;
      checkOutput({tag, "-count"}, 32'(bus.prime_count), modelCount);
   endtask

   initial begin
      int pulses;
      int numSlips;
      int cand;
      int guard;
      total       = 0;
      bad         = 0;
      modelCount  = 0;
      rst_n       = 1'b1;
      bus.auto_en = 1'b0;
      bus.start   = 1'b0;
      bus.num_in  = '0;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst-ready", 32'(bus.ready), 1);
      checkOutput("rst-valid", 32'(bus.valid), 0);
      checkOutput("rst-prime", 32'(bus.is_prime), 0);
      checkOutput("rst-number", 32'(bus.number), 0);
      checkOutput("rst-count", 32'(bus.prime_count), 0);
      rst_n = 1'b0;

      // Directed single tests
      applyStimulus(2, "n2");
      applyStimulus(4, "n4");
      applyStimulus(7, "n7");
      applyStimulus(9, "n9");
      applyStimulus(0, "n0");
      applyStimulus(1, "n1");
      applyStimulus(255, "n255");

      // Random single tests
      for (int i = 0; i < 16; i++) begin
         applyStimulus(int'($urandom_range(255, 0)), $sformatf("rnd%0d", i));
      end

      // Second start while busy must be ignored
      waitReady("busy");
      bus.num_in = 8'd97;
      bus.start  = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      pulses   = 0;
      numSlips = 0;
      for (int c = 0; c < 120; c++) begin
         @(negedge clk);
         if (c == 3) begin
            bus.num_in = 8'd55;
            bus.start  = 1'b1;
         end
         if (c == 5) bus.start = 1'b0;
         if (bus.number !== 8'd97) numSlips++;
         if (bus.valid) begin
            pulses++;
            checkOutput("busy-prime", 32'(bus.is_prime), 1);
         end
      end
      checkOutput("busy-pulses", pulses, 1);
      checkOutput("busy-number", numSlips, 0);
      modelCount++;
      checkOutput("busy-count", 32'(bus.prime_count), modelCount);

      // Reset in the middle of a division aborts the test
      waitReady("abort");
      bus.num_in = 8'd251;
      bus.start  = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      #2;
      checkOutput("abort-ready", 32'(bus.ready), 1);
      checkOutput("abort-valid", 32'(bus.valid), 0);
      checkOutput("abort-prime", 32'(bus.is_prime), 0);
      checkOutput("abort-number", 32'(bus.number), 0);
      checkOutput("abort-count", 32'(bus.prime_count), 0);
      @(negedge clk);
      rst_n = 1'b0;
      modelCount = 0;
      pulses = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (bus.valid) pulses++;
      end
      checkOutput("abort-noValid", pulses, 0);
      applyStimulus(251, "n251");

      // Auto-scan through the wrap back to zero
      @(negedge clk);
      rst_n       = 1'b1;
      bus.auto_en = 1'b1;
      @(negedge clk);
      rst_n      = 1'b0;
      modelCount = 0;
      cand       = 1;
      pulses     = 0;
      guard      = 0;
      while (pulses < 256 && guard < 60000) begin
         @(negedge clk);
         guard++;
         if (bus.valid) begin
            checkOutput($sformatf("auto-number%0d", cand), 32'(bus.number), cand);
            checkOutput($sformatf("auto-prime%0d", cand), 32'(bus.is_prime), 32'(isPrimeRef(cand)));
            if (isPrimeRef(cand)) modelCount++;
            pulses++;
            cand = (cand + 1) % 256;
         end
      end
      bus.auto_en = 1'b0;
      checkOutput("auto-pulses", pulses, 256);
      checkOutput("auto-modelPrimes", modelCount, 54);
      checkOutput("auto-count", 32'(bus.prime_count), 54);
      checkOutput("auto-lastNumber", 32'(bus.number), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
